kfx86_alu_arbiter: RTL

Sequencer and arbiter that shares the single KFX86_Accumulator (ALU) between two requesters: requester 0 is the execution unit and requester 1 is the address/string unit. It registers the operands into the ALU and captures the ALU result and flags one cycle later. It then returns them to the winning requester with a done pulse and a write-enable that is suppressed for CMP. It sits between the requesters and the purely combinational ALU instance, and it owns all ALU input drive.

---
 rtl/kfx86_alu_arbiter_pkg.sv | 16 +
 rtl/kfx86_accumulator_defs.sv | 30 +++
 rtl/kfx86_rr_pick2.sv | 15 +
 rtl/kfx86_alu_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/kfx86_alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter.
package kfx86_alu_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef logic req_idx_t;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [15:0] source_1;
    logic [15:0] source_2;
    logic [15:0] flags;
    logic        select_word;
  } req_bundle_t;

endpackage

// File: rtl/kfx86_accumulator_defs.sv
// Accumulator ALU shared definitions: opcode constants and the FLAGS register layout.
`ifndef KFX86_ACCUMULATOR_DEFS
`define KFX86_ACCUMULATOR_DEFS

`define ALU_OP_ADD 5'h00
`define ALU_OP_OR  5'h01
`define ALU_OP_ADC 5'h02
`define ALU_OP_SBB 5'h03
`define ALU_OP_AND 5'h04
`define ALU_OP_SUB 5'h05
`define ALU_OP_XOR 5'h06
`define ALU_OP_CMP 5'h07

typedef struct packed {
  logic [3:0] rsv_15_12;
  logic       o;
  logic       d;
  logic       i;
  logic       t;
  logic       s;
  logic       z;
  logic       rsv_5;
  logic       a;
  logic       rsv_3;
  logic       p;
  logic       rsv_1;
  logic       c;
} flags_t;

`endif

// File: rtl/kfx86_rr_pick2.sv
// Combinational round-robin pick between two requesters.
module kfx86_rr_pick2
  import kfx86_alu_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last,
  output logic       valid,
  output req_idx_t   winner
);

  // On a tie the requester that did not win last time goes next.
  assign valid  = |req;
  assign winner = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/kfx86_alu_arbiter.sv
// Sequences ALU ops for the execution and address units: load, settle one cycle, capture, return.
`ifndef KFX86_ACCUMULATOR_DEFS
`include "kfx86_accumulator_defs.sv"
`endif

module kfx86_alu_arbiter
  import kfx86_alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [4:0]          req_opcode_0,
  input  logic [4:0]          req_opcode_1,
  input  logic [15:0]         req_source_1_0,
  input  logic [15:0]         req_source_1_1,
  input  logic [15:0]         req_source_2_0,
  input  logic [15:0]         req_source_2_1,
  input  flags_t              req_flags_0,
  input  flags_t              req_flags_1,
  input  logic                req_select_word_0,
  input  logic                req_select_word_1,
  output logic [NUM_REQ-1:0]  grant,
  output logic [NUM_REQ-1:0]  done,
  output logic [15:0]         result,
  output flags_t              result_flags,
  output logic                result_write,
  output logic [4:0]          alu_opcode,
  output logic [15:0]         alu_source_1,
  output logic [15:0]         alu_source_2,
  output flags_t              alu_source_flags,
  output logic                alu_select_word,
  input  logic [15:0]         alu_out,
  input  flags_t              alu_out_flags
);

  state_t      state, state_nxt;
  req_bundle_t bundle [NUM_REQ];
  req_bundle_t sel;
  req_idx_t    last, winner_q, pick;
  logic        pick_valid;
  logic        load;

  assign bundle[0] = '{opcode: req_opcode_0, source_1: req_source_1_0, source_2: req_source_2_0,
                       flags: req_flags_0, select_word: req_select_word_0};
  assign bundle[1] = '{opcode: req_opcode_1, source_1: req_source_1_1, source_2: req_source_2_1,
                       flags: req_flags_1, select_word: req_select_word_1};

  kfx86_rr_pick2 u_pick (
    .req    (req),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick)
  );

  assign sel  = bundle[pick];
  // DONE re-arbitrates like IDLE so back-to-back ops need no idle cycle.
  assign load = pick_valid && (state == IDLE || state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = pick_valid ? BUSY : IDLE;
      BUSY:    state_nxt = DONE;
      DONE:    state_nxt = pick_valid ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done         = '0;
    result_write = 1'b0;
    if (state == DONE) begin
      done[winner_q] = 1'b1;
      result_write   = (alu_opcode != `ALU_OP_CMP);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant            <= '0;
      last             <= 1'b1;
      winner_q         <= 1'b0;
      alu_opcode       <= `ALU_OP_ADD;
      alu_source_1     <= '0;
      alu_source_2     <= '0;
      alu_source_flags <= '0;
      alu_select_word  <= 1'b1;
      result           <= '0;
      result_flags     <= '0;
    end else begin
      if (load) begin
        grant            <= NUM_REQ'(1) << pick;
        last             <= pick;
        winner_q         <= pick;
        alu_opcode       <= sel.opcode;
        alu_source_1     <= sel.source_1;
        alu_source_2     <= sel.source_2;
        alu_source_flags <= sel.flags;
        alu_select_word  <= sel.select_word;
      end else if (state == DONE) begin
        grant <= '0;
      end
      // The ALU has had the full BUSY cycle to settle on the registered operands.
      if (state == BUSY) begin
        result       <= alu_out;
        result_flags <= alu_out_flags;
      end
    end
  end

endmodule
